// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TAP / debug transport module: TAP states,
// instruction codes and DMI op/status encodings.
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_RESET,
        TAP_IDLE,
        TAP_SEL_DR,
        TAP_CAP_DR,
        TAP_SHIFT_DR,
        TAP_EXIT1_DR,
        TAP_PAUSE_DR,
        TAP_EXIT2_DR,
        TAP_UPD_DR,
        TAP_SEL_IR,
        TAP_CAP_IR,
        TAP_SHIFT_IR,
        TAP_EXIT1_IR,
        TAP_PAUSE_IR,
        TAP_EXIT2_IR,
        TAP_UPD_IR
    } tap_state_e;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;
    localparam logic [4:0] IR_BYPASS = 5'h1F;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    localparam logic [1:0] DMI_STAT_OK   = 2'd0;
    localparam logic [1:0] DMI_STAT_BUSY = 2'd3;

    function automatic logic is_dmi_op(input logic [1:0] op);
        return (op == DMI_OP_READ) || (op == DMI_OP_WRITE);
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller state machine, stepped by a detected TCK rise.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       tck_rise,
    input  logic       tms,
    input  logic       trst,
    output tap_state_e state
);

    tap_state_e state_q, state_d;

    assign state = state_q;

    // Next-state decode; TRST overrides any TCK activity
    always_comb begin
        state_d = state_q;
        if (trst) begin
            state_d = TAP_RESET;
        end else if (tck_rise) begin
            case (state_q)
                TAP_RESET:    state_d = tms ? TAP_RESET    : TAP_IDLE;
                TAP_IDLE:     state_d = tms ? TAP_SEL_DR   : TAP_IDLE;
                TAP_SEL_DR:   state_d = tms ? TAP_SEL_IR   : TAP_CAP_DR;
                TAP_CAP_DR:   state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_SHIFT_DR: state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_EXIT1_DR: state_d = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
                TAP_PAUSE_DR: state_d = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
                TAP_EXIT2_DR: state_d = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
                TAP_UPD_DR:   state_d = tms ? TAP_SEL_DR   : TAP_IDLE;
                TAP_SEL_IR:   state_d = tms ? TAP_RESET    : TAP_CAP_IR;
                TAP_CAP_IR:   state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_SHIFT_IR: state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_EXIT1_IR: state_d = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
                TAP_PAUSE_IR: state_d = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
                TAP_EXIT2_IR: state_d = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
                TAP_UPD_IR:   state_d = tms ? TAP_SEL_DR   : TAP_IDLE;
                default:      state_d = TAP_RESET;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= TAP_RESET;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/jtag_tap_dtm.sv
// JTAG debug transport module: oversampled TAP with IDCODE/DTMCS/DMI/BYPASS
// registers and a valid/ready DMI request port with a single outstanding slot.
module jtag_tap_dtm
    import jtag_pkg::*;
#(
    parameter logic [31:0] IDCODE = 32'h00000001,
    parameter int          ABITS  = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             jtag_TCK,
    input  logic             jtag_TMS,
    input  logic             jtag_TDI,
    input  logic             jtag_TRSTn,
    output logic             jtag_TDO_data,
    output logic             jtag_TDO_driven,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_resp_valid,
    input  logic [31:0]      dmi_resp_data,
    input  logic [1:0]       dmi_resp_op
);

    localparam int DMI_LEN = ABITS + 34;
    localparam int SHW     = (DMI_LEN > 32) ? DMI_LEN : 32;
    localparam int LW      = $clog2(SHW);

    logic             tck_q;
    logic             tck_rise_s, tck_fall_s, trst_s;
    tap_state_e       state_s;
    logic [4:0]       ir_q, ir_d;
    logic [SHW-1:0]   shift_q, shift_d, shifted_s, dr_capture_s;
    logic [LW-1:0]    dr_msb_s, shift_msb_s;
    logic             tdo_data_q, tdo_data_d, tdo_driven_q, tdo_driven_d;
    logic             req_valid_q, req_valid_d, pending_q, pending_d, busy_q, busy_d;
    logic [31:0]      resp_data_q, resp_data_d, req_data_q, req_data_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [1:0]       req_op_q, req_op_d, stat_s;
    logic             handshake_s, resp_take_s;

    assign tck_rise_s = jtag_TCK & ~tck_q;
    assign tck_fall_s = ~jtag_TCK & tck_q;
    assign trst_s     = ~jtag_TRSTn;
    assign stat_s     = busy_q ? DMI_STAT_BUSY : DMI_STAT_OK;

    jtag_tap_fsm u_fsm (
        .clock    (clock),
        .reset    (reset),
        .tck_rise (tck_rise_s),
        .tms      (jtag_TMS),
        .trst     (trst_s),
        .state    (state_s)
    );

    // Data register selection: capture value and chain MSB position
    always_comb begin
        dr_capture_s = {SHW{1'b0}};
        dr_msb_s     = LW'(0);
        case (ir_q)
            IR_IDCODE: begin
                dr_capture_s = SHW'(IDCODE);
                dr_msb_s     = LW'(31);
            end
            IR_DTMCS: begin
                dr_capture_s = SHW'({14'd0, 1'b0, 1'b0, 1'b0, 3'd1, stat_s, 6'(ABITS), 4'd1});
                dr_msb_s     = LW'(31);
            end
            IR_DMI: begin
                dr_capture_s = SHW'({addr_q, resp_data_q, stat_s});
                dr_msb_s     = LW'(DMI_LEN - 1);
            end
            default: begin
                dr_capture_s = {SHW{1'b0}};
                dr_msb_s     = LW'(0);
            end
        endcase
        shift_msb_s = (state_s == TAP_SHIFT_IR) ? LW'(4) : dr_msb_s;
        shifted_s   = {1'b0, shift_q[SHW-1:1]};
        shifted_s[shift_msb_s] = jtag_TDI;
    end

    // DMI handshake/response tracking, then TAP register actions on TCK edges
    always_comb begin
        handshake_s  = req_valid_q & dmi_req_ready;
        resp_take_s  = pending_q & dmi_resp_valid;
        req_valid_d  = handshake_s ? 1'b0 : req_valid_q;
        pending_d    = (pending_q & ~resp_take_s) | handshake_s;
        busy_d       = busy_q | (resp_take_s & (dmi_resp_op != DMI_OP_NOP));
        resp_data_d  = resp_take_s ? dmi_resp_data : resp_data_q;
        addr_d       = addr_q;
        req_data_d   = req_data_q;
        req_op_d     = req_op_q;
        ir_d         = ir_q;
        shift_d      = shift_q;
        tdo_data_d   = tdo_data_q;
        tdo_driven_d = tdo_driven_q;

        if (tck_rise_s) begin
            case (state_s)
                TAP_CAP_IR:   shift_d = SHW'(5'b00001);
                TAP_SHIFT_IR: shift_d = shifted_s;
                TAP_UPD_IR:   ir_d    = shift_q[4:0];
                TAP_CAP_DR:   shift_d = dr_capture_s;
                TAP_SHIFT_DR: shift_d = shifted_s;
                TAP_UPD_DR: begin
                    case (ir_q)
                        IR_DMI: begin
                            if (is_dmi_op(shift_q[1:0]) && !req_valid_q && !pending_q && !busy_q) begin
                                addr_d      = shift_q[DMI_LEN-1:34];
                                req_data_d  = shift_q[33:2];
                                req_op_d    = shift_q[1:0];
                                req_valid_d = 1'b1;
                            end else begin
                                busy_d = busy_d | is_dmi_op(shift_q[1:0]);
                            end
                        end
                        IR_DTMCS: begin
                            busy_d      = (shift_q[16] | shift_q[17]) ? 1'b0 : busy_d;
                            pending_d   = shift_q[17] ? 1'b0 : pending_d;
                            req_valid_d = shift_q[17] ? 1'b0 : req_valid_d;
                        end
                        default: ir_d = ir_q;
                    endcase
                end
                default: shift_d = shift_q;
            endcase
        end else begin
            shift_d = shift_q;
        end

        ir_d = (trst_s || (state_s == TAP_RESET)) ? IR_IDCODE : ir_d;

        if (trst_s) begin
            tdo_data_d   = 1'b0;
            tdo_driven_d = 1'b0;
        end else if (tck_fall_s) begin
            tdo_driven_d = (state_s == TAP_SHIFT_IR) || (state_s == TAP_SHIFT_DR);
            tdo_data_d   = tdo_driven_d & shift_q[0];
        end else begin
            tdo_data_d   = tdo_data_q;
        end
    end

    // Register bank; reset abandons any in-flight DMI transaction
    always_ff @(posedge clock) begin
        if (reset) begin
            tck_q        <= 1'b0;
            ir_q         <= IR_IDCODE;
            shift_q      <= {SHW{1'b0}};
            tdo_data_q   <= 1'b0;
            tdo_driven_q <= 1'b0;
            req_valid_q  <= 1'b0;
            pending_q    <= 1'b0;
            busy_q       <= 1'b0;
            resp_data_q  <= 32'd0;
            addr_q       <= {ABITS{1'b0}};
            req_data_q   <= 32'd0;
            req_op_q     <= DMI_OP_NOP;
        end else begin
            tck_q        <= jtag_TCK;
            ir_q         <= ir_d;
            shift_q      <= shift_d;
            tdo_data_q   <= tdo_data_d;
            tdo_driven_q <= tdo_driven_d;
            req_valid_q  <= req_valid_d;
            pending_q    <= pending_d;
            busy_q       <= busy_d;
            resp_data_q  <= resp_data_d;
            addr_q       <= addr_d;
            req_data_q   <= req_data_d;
            req_op_q     <= req_op_d;
        end
    end

    assign jtag_TDO_data   = tdo_data_q;
    assign jtag_TDO_driven = tdo_driven_q;
    assign dmi_req_valid   = req_valid_q;
    assign dmi_req_addr    = addr_q;
    assign dmi_req_data    = req_data_q;
    assign dmi_req_op      = req_op_q;

endmodule

// File: tb/tb_jtag_tap_dtm.sv
// Scoreboarded bench for jtag_tap_dtm: TCK is bit-banged at a quarter of the
// system clock rate, captured register contents are checked against a queue.
module tb_jtag_tap_dtm;

    localparam int ABITS = 7;

    logic             clock = 1'b0;
    logic             reset;
    logic             jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
    logic             jtag_TDO_data, jtag_TDO_driven;
    logic             dmi_req_valid, dmi_req_ready;
    logic [ABITS-1:0] dmi_req_addr;
    logic [31:0]      dmi_req_data;
    logic [1:0]       dmi_req_op;
    logic             dmi_resp_valid;
    logic [31:0]      dmi_resp_data;
    logic [1:0]       dmi_resp_op;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    jtag_tap_dtm #(.IDCODE(32'h00000001), .ABITS(ABITS)) dut (
        .clock           (clock),
        .reset           (reset),
        .jtag_TCK        (jtag_TCK),
        .jtag_TMS        (jtag_TMS),
        .jtag_TDI        (jtag_TDI),
        .jtag_TRSTn      (jtag_TRSTn),
        .jtag_TDO_data   (jtag_TDO_data),
        .jtag_TDO_driven (jtag_TDO_driven),
        .dmi_req_valid   (dmi_req_valid),
        .dmi_req_ready   (dmi_req_ready),
        .dmi_req_addr    (dmi_req_addr),
        .dmi_req_data    (dmi_req_data),
        .dmi_req_op      (dmi_req_op),
        .dmi_resp_valid  (dmi_resp_valid),
        .dmi_resp_data   (dmi_resp_data),
        .dmi_resp_op     (dmi_resp_op)
    );

    always #5 clock = ~clock;

    // One TCK period; returns TDO as seen after the falling edge.
    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
        jtag_TMS = tms;
        jtag_TDI = tdi;
        jtag_TCK = 1'b1;
        repeat (2) @(negedge clock);
        jtag_TCK = 1'b0;
        repeat (2) @(negedge clock);
        tdo = jtag_TDO_data;
    endtask

    // Run-Test-Idle -> scan n bits -> Update -> Run-Test-Idle.
    task automatic scan(input logic is_ir, input int n, input logic [63:0] din, output logic [63:0] dout);
        logic t;
        dout = 64'd0;
        tck_cycle(1'b1, 1'b0, t);
        if (is_ir) tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        for (int i = 0; i < n; i++) begin
            dout[i] = t;
            tck_cycle((i == n - 1), din[i], t);
        end
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
    endtask

    function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        return {23'd0, a, d, op};
    endfunction

    task automatic handshake_and_respond(input logic [31:0] data, input logic [1:0] op);
        dmi_req_ready = 1'b1;
        @(negedge clock);
        dmi_req_ready = 1'b0;
        @(negedge clock);
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = data;
        dmi_resp_op    = op;
        @(negedge clock);
        dmi_resp_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        logic [63:0] got, exp;
        logic t;
        reset = 1'b1; jtag_TRSTn = 1'b1; jtag_TCK = 1'b0; jtag_TMS = 1'b0; jtag_TDI = 1'b0;
        dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0; dmi_resp_data = 32'd0; dmi_resp_op = 2'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        total++; if (dmi_req_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", dmi_req_valid); end
        total++; if (jtag_TDO_driven !== 1'b0) begin bad++; $display("FAIL rst_driven got=%b exp=0", jtag_TDO_driven); end
        total++; if (jtag_TDO_data !== 1'b0) begin bad++; $display("FAIL rst_tdo got=%b exp=0", jtag_TDO_data); end
        total++; if (dmi_req_addr !== 7'd0) begin bad++; $display("FAIL rst_addr got=%h exp=0", dmi_req_addr); end
        tck_cycle(1'b0, 1'b0, t);
        exp_q.push_back(64'h1);
        scan(1'b0, 32, 64'd0, got);
        exp = exp_q.pop_front();
        total++; if (got !== exp) begin bad++; $display("FAIL rst_idcode got=%h exp=%h", got, exp); end
    endtask

    task automatic test_idcode_trst();
        logic [63:0] got, exp;
        logic t;
        jtag_TRSTn = 1'b0;
        repeat (2) @(negedge clock);
        jtag_TRSTn = 1'b1;
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        exp_q.push_back(64'h1);
        scan(1'b0, 32, 64'hFFFF_FFFF, got);
        exp = exp_q.pop_front();
        total++; if (got !== exp) begin bad++; $display("FAIL idcode got=%h exp=%h", got, exp); end
    endtask

    task automatic test_bypass();
        logic [63:0] got, exp;
        logic [4:0]  codes [2] = '{5'h1F, 5'h05};
        logic [8:0]  pats  [2] = '{9'h0A5, 9'h03C};
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(64'h01);
            scan(1'b1, 5, {59'd0, codes[k]}, got);
            exp = exp_q.pop_front();
            total++; if (got !== exp) begin bad++; $display("FAIL ir_capture got=%h exp=%h", got, exp); end
            exp_q.push_back({55'd0, pats[k][7:0], 1'b0});
            scan(1'b0, 9, {55'd0, pats[k]}, got);
            exp = exp_q.pop_front();
            total++; if (got !== exp) begin bad++; $display("FAIL bypass%0d got=%h exp=%h", k, got, exp); end
        end
    endtask

    task automatic test_dtmcs();
        logic [63:0] got, exp;
        scan(1'b1, 5, 64'h10, got);
        exp_q.push_back(64'h0000_1071);
        scan(1'b0, 32, 64'd0, got);
        exp = exp_q.pop_front();
        total++; if (got !== exp) begin bad++; $display("FAIL dtmcs got=%h exp=%h", got, exp); end
    endtask

    task automatic test_dmi_write();
        logic [63:0] got, exp;
        scan(1'b1, 5, 64'h11, got);
        scan(1'b0, 41, dmi_word(7'h10, 32'h1, 2'd2), got);
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op} !== {1'b1, 7'h10, 32'h1, 2'd2}) begin
                bad++; $display("FAIL wr_hold%0d got=%b/%h/%h/%h exp=1/10/1/2", c, dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op);
            end
            @(negedge clock);
        end
        dmi_req_ready = 1'b1;
        @(negedge clock);
        dmi_req_ready = 1'b0;
        total++; if (dmi_req_valid !== 1'b0) begin bad++; $display("FAIL wr_drop got=%b exp=0", dmi_req_valid); end
        dmi_resp_valid = 1'b1; dmi_resp_data = 32'h0; dmi_resp_op = 2'd0;
        @(negedge clock);
        dmi_resp_valid = 1'b0;
        repeat (2) @(negedge clock);
        // stray response with nothing pending must be ignored
        dmi_resp_valid = 1'b1; dmi_resp_data = 32'h0BAD_0BAD; dmi_resp_op = 2'd3;
        @(negedge clock);
        dmi_resp_valid = 1'b0;
        exp_q.push_back(dmi_word(7'h10, 32'h0, 2'd0));
        scan(1'b0, 41, 64'd0, got);
        exp = exp_q.pop_front();
        total++; if (got !== exp) begin bad++; $display("FAIL wr_capture got=%h exp=%h", got, exp); end
        scan(1'b0, 41, dmi_word(7'h11, 32'h0, 2'd1), got);
        total++; if ({dmi_req_valid, dmi_req_addr, dmi_req_op} !== {1'b1, 7'h11, 2'd1}) begin
            bad++; $display("FAIL rd_req got=%b/%h/%h exp=1/11/1", dmi_req_valid, dmi_req_addr, dmi_req_op);
        end
        handshake_and_respond(32'hDEAD_BEEF, 2'd0);
        exp_q.push_back(dmi_word(7'h11, 32'hDEAD_BEEF, 2'd0));
        scan(1'b0, 41, 64'd0, got);
        exp = exp_q.pop_front();
        total++; if (got !== exp) begin bad++; $display("FAIL rd_capture got=%h exp=%h", got, exp); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] got, exp;
        scan(1'b0, 41, dmi_word(7'h05, 32'hAAAA_5555, 2'd1), got);
        scan(1'b0, 41, dmi_word(7'h06, 32'h0000_1234, 2'd2), got);
        total++; if ({dmi_req_valid, dmi_req_addr, dmi_req_data} !== {1'b1, 7'h05, 32'hAAAA_5555}) begin
            bad++; $display("FAIL b2b_keep got=%b/%h/%h exp=1/05/aaaa5555", dmi_req_valid, dmi_req_addr, dmi_req_data);
        end
        exp_q.push_back(dmi_word(7'h05, 32'hDEAD_BEEF, 2'd3));
        scan(1'b0, 41, 64'd0, got);
        exp = exp_q.pop_front();
        total++; if (got !== exp) begin bad++; $display("FAIL b2b_busy got=%h exp=%h", got, exp); end
        scan(1'b1, 5, 64'h10, got);
        exp_q.push_back(64'h0000_1C71);
        scan(1'b0, 32, 64'h0001_0000, got);
        exp = exp_q.pop_front();
        total++; if (got !== exp) begin bad++; $display("FAIL dtmcs_busy got=%h exp=%h", got, exp); end
        exp_q.push_back(64'h0000_1071);
        scan(1'b0, 32, 64'd0, got);
        exp = exp_q.pop_front();
        total++; if (got !== exp) begin bad++; $display("FAIL dmireset got=%h exp=%h", got, exp); end
        handshake_and_respond(32'hCAFE_F00D, 2'd0);
        scan(1'b1, 5, 64'h11, got);
        exp_q.push_back(dmi_word(7'h05, 32'hCAFE_F00D, 2'd0));
        scan(1'b0, 41, 64'd0, got);
        exp = exp_q.pop_front();
        total++; if (got !== exp) begin bad++; $display("FAIL b2b_resp got=%h exp=%h", got, exp); end
        // error response sets busy; hard reset clears it
        scan(1'b0, 41, dmi_word(7'h07, 32'h0, 2'd1), got);
        handshake_and_respond(32'h0000_0011, 2'd2);
        exp_q.push_back(dmi_word(7'h07, 32'h0000_0011, 2'd3));
        scan(1'b0, 41, 64'd0, got);
        exp = exp_q.pop_front();
        total++; if (got !== exp) begin bad++; $display("FAIL resp_err got=%h exp=%h", got, exp); end
        scan(1'b1, 5, 64'h10, got);
        scan(1'b0, 32, 64'h0002_0000, got);
        exp_q.push_back(64'h0000_1071);
        scan(1'b0, 32, 64'd0, got);
        exp = exp_q.pop_front();
        total++; if (got !== exp) begin bad++; $display("FAIL hardreset got=%h exp=%h", got, exp); end
    endtask

    task automatic test_reset_midflight();
        logic [63:0] got;
        logic t;
        scan(1'b1, 5, 64'h11, got);
        scan(1'b0, 41, dmi_word(7'h22, 32'h99, 2'd2), got);
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        total++; if ({dmi_req_valid, jtag_TDO_driven} !== 2'b11) begin
            bad++; $display("FAIL mid_pre got=%b%b exp=11", dmi_req_valid, jtag_TDO_driven);
        end
        reset = 1'b1;
        @(negedge clock);
        total++; if ({dmi_req_valid, jtag_TDO_driven, jtag_TDO_data} !== 3'b000) begin
            bad++; $display("FAIL mid_reset got=%b%b%b exp=000", dmi_req_valid, jtag_TDO_driven, jtag_TDO_data);
        end
        reset = 1'b0;
        @(negedge clock);
        tck_cycle(1'b0, 1'b0, t);
        scan(1'b1, 5, 64'h11, got);
        scan(1'b0, 41, dmi_word(7'h23, 32'h5, 2'd2), got);
        total++; if ({dmi_req_valid, dmi_req_addr} !== {1'b1, 7'h23}) begin
            bad++; $display("FAIL post_reset_req got=%b/%h exp=1/23", dmi_req_valid, dmi_req_addr);
        end
    endtask

    initial begin
        test_reset();
        test_idcode_trst();
        test_bypass();
        test_dtmcs();
        test_dmi_write();
        test_back_to_back();
        test_reset_midflight();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
